// File: rtl/reg_file_4x8.sv
// Four-entry register file with two registered read ports and one write port.
// Ports: input_clock/input_reset, write port (enable, 2-bit select, data),
//        read enable, A/B 2-bit selects, registered A/B data and zero flags.
module reg_file_4x8 #(
    parameter int                    DATA_WIDTH   = 8,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE  = '0,
    parameter bit                    WRITE_BYPASS = 1'b1
) (
    input  logic                  input_clock,
    input  logic                  input_reset,
    input  logic                  input_write_enable,
    input  logic                  input_write_select1,
    input  logic                  input_write_select2,
    input  logic [DATA_WIDTH-1:0] input_write_data,
    input  logic                  input_read_enable,
    input  logic                  input_read_a_select1,
    input  logic                  input_read_a_select2,
    input  logic                  input_read_b_select1,
    input  logic                  input_read_b_select2,
    output logic [DATA_WIDTH-1:0] output_read_a,
    output logic [DATA_WIDTH-1:0] output_read_b,
    output logic                  output_a_zero,
    output logic                  output_b_zero
);

    localparam logic RESET_ZERO = (RESET_VALUE == '0);

    logic [1:0]            write_index;
    logic [1:0]            read_a_index;
    logic [1:0]            read_b_index;
    logic [3:0]            write_hot;
    logic [DATA_WIDTH-1:0] regs [4];
    logic [DATA_WIDTH-1:0] stored_a;
    logic [DATA_WIDTH-1:0] stored_b;
    logic                  hit_a;
    logic                  hit_b;
    logic [DATA_WIDTH-1:0] next_a;
    logic [DATA_WIDTH-1:0] next_b;

    assign write_index  = {input_write_select2, input_write_select1};
    assign read_a_index = {input_read_a_select2, input_read_a_select1};
    assign read_b_index = {input_read_b_select2, input_read_b_select1};

    always_comb begin
        write_hot = '0;
        unique case (1'b1)
            (write_index == 2'd0): write_hot[0] = input_write_enable;
            (write_index == 2'd1): write_hot[1] = input_write_enable;
            (write_index == 2'd2): write_hot[2] = input_write_enable;
            (write_index == 2'd3): write_hot[3] = input_write_enable;
            default:               write_hot    = '0;
        endcase
    end

    always_ff @(posedge input_clock or posedge input_reset) begin
        if (input_reset) begin
            for (int i = 0; i < 4; i++) begin
                regs[i] <= RESET_VALUE;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (write_hot[i]) begin
                    regs[i] <= input_write_data;
                end
            end
        end
    end

    assign stored_a = regs[read_a_index];
    assign stored_b = regs[read_b_index];

    // A port collides when the same edge writes the register it reads.
    assign hit_a = input_write_enable && (write_index == read_a_index);
    assign hit_b = input_write_enable && (write_index == read_b_index);

    always_comb begin
        next_a = stored_a;
        next_b = stored_b;
        if (WRITE_BYPASS && hit_a) begin
            next_a = input_write_data;
        end
        if (WRITE_BYPASS && hit_b) begin
            next_b = input_write_data;
        end
    end

    // Flags are computed from the value being captured so they always
    // match the data outputs they sit beside.
    always_ff @(posedge input_clock or posedge input_reset) begin
        if (input_reset) begin
            output_read_a <= RESET_VALUE;
            output_read_b <= RESET_VALUE;
            output_a_zero <= RESET_ZERO;
            output_b_zero <= RESET_ZERO;
        end else if (input_read_enable) begin
            output_read_a <= next_a;
            output_read_b <= next_b;
            output_a_zero <= (next_a == '0);
            output_b_zero <= (next_b == '0);
        end
    end

endmodule

// File: tb/tb_reg_file_4x8.sv
// Testbench for reg_file_4x8: array model plus directed literal checks.
// Two instances cover write-first and read-old collision behaviour.
module tb_reg_file_4x8;

    logic       clk;
    logic       rst;
    logic       we;
    logic       ws1, ws2;
    logic [7:0] wd;
    logic       re;
    logic       as1, as2, bs1, bs2;

    logic [7:0] a1, b1, a0, b0;
    logic       az1, bz1, az0, bz0;

    int n_cmp;
    int n_bad;
    bit started;

    reg_file_4x8 #(.DATA_WIDTH(8), .RESET_VALUE(8'h00), .WRITE_BYPASS(1'b1)) u_byp (
        .input_clock(clk), .input_reset(rst),
        .input_write_enable(we),
        .input_write_select1(ws1), .input_write_select2(ws2),
        .input_write_data(wd), .input_read_enable(re),
        .input_read_a_select1(as1), .input_read_a_select2(as2),
        .input_read_b_select1(bs1), .input_read_b_select2(bs2),
        .output_read_a(a1), .output_read_b(b1),
        .output_a_zero(az1), .output_b_zero(bz1)
    );

    reg_file_4x8 #(.DATA_WIDTH(8), .RESET_VALUE(8'h00), .WRITE_BYPASS(1'b0)) u_old (
        .input_clock(clk), .input_reset(rst),
        .input_write_enable(we),
        .input_write_select1(ws1), .input_write_select2(ws2),
        .input_write_data(wd), .input_read_enable(re),
        .input_read_a_select1(as1), .input_read_a_select2(as2),
        .input_read_b_select1(bs1), .input_read_b_select2(bs2),
        .output_read_a(a0), .output_read_b(b0),
        .output_a_zero(az0), .output_b_zero(bz0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: register array plus the value each port last captured,
    // once with write-first and once with read-old resolution.
    logic [7:0] m_reg [4];
    logic [7:0] m_a1, m_b1, m_a0, m_b0;

    always @(posedge clk or posedge rst) begin
        int wi, ai, bi;
        if (rst) begin
            for (int i = 0; i < 4; i++) m_reg[i] = 8'h00;
            m_a1 = 8'h00; m_b1 = 8'h00;
            m_a0 = 8'h00; m_b0 = 8'h00;
        end else begin
            wi = 2 * int'(ws2) + int'(ws1);
            ai = 2 * int'(as2) + int'(as1);
            bi = 2 * int'(bs2) + int'(bs1);
            if (re) begin
                m_a0 = m_reg[ai];
                m_b0 = m_reg[bi];
                m_a1 = (we && wi == ai) ? wd : m_reg[ai];
                m_b1 = (we && wi == bi) ? wd : m_reg[bi];
            end
            if (we) m_reg[wi] = wd;
        end
    end

    task automatic chk8(input string name, input logic [7:0] act,
                        input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            chk8("cyc_a_byp", a1, m_a1);
            chk8("cyc_b_byp", b1, m_b1);
            chk8("cyc_a_old", a0, m_a0);
            chk8("cyc_b_old", b0, m_b0);
            chk1("cyc_az_byp", az1, m_a1 == 8'h00);
            chk1("cyc_bz_byp", bz1, m_b1 == 8'h00);
            chk1("cyc_az_old", az0, m_a0 == 8'h00);
            chk1("cyc_bz_old", bz0, m_b0 == 8'h00);
        end
    end

    task automatic set_w(input logic e, input int idx, input logic [7:0] d);
        we  = e;
        ws1 = idx[0];
        ws2 = idx[1];
        wd  = d;
    endtask

    task automatic set_r(input logic e, input int ai, input int bi);
        re  = e;
        as1 = ai[0];
        as2 = ai[1];
        bs1 = bi[0];
        bs2 = bi[1];
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    logic [7:0] wvals [4];

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        started = 1'b0;
        rst     = 1'b0;
        set_w(1'b0, 0, 8'h00);
        set_r(1'b0, 0, 0);
        wvals[0] = 8'h00; wvals[1] = 8'hF0;
        wvals[2] = 8'h0F; wvals[3] = 8'hFF;

        // Reset mid-cycle with a write pending; the write must be lost.
        tick();
        set_w(1'b1, 0, 8'h33);
        set_r(1'b1, 0, 0);
        #1 rst = 1'b1;
        #1;
        chk8("rst_async_a", a1, 8'h00);
        chk8("rst_async_b", b1, 8'h00);
        chk1("rst_async_az", az1, 1'b1);
        chk1("rst_async_bz", bz1, 1'b1);
        started = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        set_w(1'b0, 0, 8'h00);
        tick();
        chk8("rst_write_lost", a1, 8'h00);

        // Fill the file, then read each entry on port A.
        set_r(1'b0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            set_w(1'b1, i, wvals[i]);
            tick();
        end
        set_w(1'b0, 0, 8'h00);
        for (int i = 0; i < 4; i++) begin
            set_r(1'b1, i, 0);
            tick();
            chk8($sformatf("read_a_r%0d", i), a1, wvals[i]);
            chk1($sformatf("zero_a_r%0d", i), az1, i == 0);
        end

        // Both ports in parallel.
        set_r(1'b1, 2, 3);
        tick();
        chk8("dual_a", a1, 8'h0F);
        chk8("dual_b", b1, 8'hFF);
        chk1("dual_bz", bz1, 1'b0);

        // Collision on R1 from both ports.
        set_w(1'b1, 1, 8'hAA);
        set_r(1'b1, 1, 1);
        tick();
        chk8("coll_byp_a", a1, 8'hAA);
        chk8("coll_byp_b", b1, 8'hAA);
        chk8("coll_old_a", a0, 8'hF0);
        chk8("coll_old_b", b0, 8'hF0);
        set_w(1'b0, 0, 8'h00);
        tick();
        chk8("coll_old_next_a", a0, 8'hAA);
        chk8("coll_old_next_b", b0, 8'hAA);

        // Hold while writing R3, then read it back on B.
        set_w(1'b1, 3, 8'h55);
        set_r(1'b0, 0, 2);
        tick();
        chk8("hold_a", a1, 8'hAA);
        chk8("hold_b", b1, 8'hAA);
        set_w(1'b0, 0, 8'h00);
        tick();
        chk8("hold2_b", b1, 8'hAA);
        set_r(1'b1, 0, 3);
        tick();
        chk8("after_hold_b", b1, 8'h55);
        chk8("after_hold_a", a1, 8'h00);

        // Reset pulse with nonzero contents, then read everything back.
        rst = 1'b1;
        #1;
        chk8("pulse_rst_b", b1, 8'h00);
        #1 rst = 1'b0;
        set_r(1'b1, 1, 3);
        tick();
        chk8("post_rst_r1", a1, 8'h00);
        chk8("post_rst_r3", b1, 8'h00);
        chk1("post_rst_bz", bz1, 1'b1);
        set_r(1'b1, 2, 0);
        tick();
        chk8("post_rst_r2", a1, 8'h00);
        chk8("post_rst_r0", b1, 8'h00);

        // Mixed traffic checked by the per-cycle model comparison.
        for (int i = 0; i < 40; i++) begin
            set_w(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                  8'($urandom_range(0, 255)));
            set_r(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)));
            tick();
        end
        set_w(1'b0, 0, 8'h00);
        set_r(1'b0, 0, 0);
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
